// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: free-running h/v counters, a registered decode
// stage and OUT_DLY extra stages, all advancing only on the pixel enable CE.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CW        = 11,
    parameter int OUT_DLY   = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          VIDEO_ON,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          LINE_START,
    output logic          FRAME_START,
    output logic          FRAME_END
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    // Clamped so array bounds stay legal even when the sanity check below fires.
    localparam int LAST    = (OUT_DLY < 0) ? 0 : ((OUT_DLY > 4) ? 4 : OUT_DLY);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS      = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS      = CW'(V_DISPLAY);
    localparam logic [CW-1:0] H_VIS_LAST = CW'(H_DISPLAY - 1);
    localparam logic [CW-1:0] V_VIS_LAST = CW'(V_DISPLAY - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_DISPLAY + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_DISPLAY + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic          H_ACT      = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          V_ACT      = (V_POL != 0) ? 1'b1 : 1'b0;

    if (H_DISPLAY <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_DISPLAY <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        OUT_DLY < 0 || OUT_DLY > 4 ||
        (64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_param_check
        $fatal(1, "vga_timing_gen: illegal parameter set");
    end

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          vid;
        logic          line_start;
        logic          frame_start;
        logic          frame_end;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } out_t;

    function automatic out_t rst_val();
        out_t r;
        r             = '0;
        r.hsync       = ~H_ACT;
        r.vsync       = ~V_ACT;
        return r;
    endfunction

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    out_t          dec_s;
    out_t          pipe_q [0:LAST];
    out_t          pipe_d [0:LAST];

    // Combinational decode of the current counter position.
    always_comb begin
        dec_s             = '0;
        dec_s.hsync       = (h_q >= HS_FIRST && h_q <= HS_LAST) ? H_ACT : ~H_ACT;
        dec_s.vsync       = (v_q >= VS_FIRST && v_q <= VS_LAST) ? V_ACT : ~V_ACT;
        dec_s.vid         = (h_q < H_VIS) && (v_q < V_VIS);
        dec_s.line_start  = (h_q == '0);
        dec_s.frame_start = (h_q == '0) && (v_q == '0);
        dec_s.frame_end   = (h_q == H_VIS_LAST) && (v_q == V_VIS_LAST);
        dec_s.x           = h_q;
        dec_s.y           = v_q;
    end

    // Next state of counters and pipeline; RESET wins over CE, CE=0 holds everything.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        pipe_d = pipe_q;
        if (RESET) begin
            h_d = '0;
            v_d = '0;
            for (int i = 0; i <= LAST; i++) begin
                pipe_d[i] = rst_val();
            end
        end else if (CE) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                h_d = h_q + {{(CW-1){1'b0}}, 1'b1};
            end
            pipe_d[0] = dec_s;
            for (int i = 1; i <= LAST; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end else begin
            h_d = h_q;
        end
    end

    // State register for counters and every output stage.
    always_ff @(posedge CLK) begin
        h_q    <= h_d;
        v_q    <= v_d;
        pipe_q <= pipe_d;
    end

    assign HSYNC       = pipe_q[LAST].hsync;
    assign VSYNC       = pipe_q[LAST].vsync;
    assign VIDEO_ON    = pipe_q[LAST].vid;
    assign LINE_START  = pipe_q[LAST].line_start;
    assign FRAME_START = pipe_q[LAST].frame_start;
    assign FRAME_END   = pipe_q[LAST].frame_end;
    assign X           = pipe_q[LAST].x;
    assign Y           = pipe_q[LAST].y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (small geometry at two depths, inverted
// polarity, default 640x480) checked every clock against an arithmetic frame model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
        logic        fe;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    typedef struct {
        int   k;
        exp_t e;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic ce_s = 1'b0;
    logic ce_b = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_s = 0;
    int   n_b = 0;

    logic       hs_a, vs_a, vid_a, ls_a, fs_a, fe_a;
    logic [3:0] x_a, y_a;
    logic       hs_b, vs_b, vid_b, ls_b, fs_b, fe_b;
    logic [3:0] x_b, y_b;
    logic       hs_p, vs_p, vid_p, ls_p, fs_p, fe_p;
    logic [3:0] x_p, y_p;
    logic       hs_g, vs_g, vid_g, ls_g, fs_g, fe_g;
    logic [10:0] x_g, y_g;

    always #5 CLK = ~CLK;

    vga_timing_gen #(.H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_DISPLAY(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(0), .V_POL(0), .CW(4), .OUT_DLY(0)) u_a (
        .CLK(CLK), .RESET(RESET), .CE(ce_s), .HSYNC(hs_a), .VSYNC(vs_a), .VIDEO_ON(vid_a),
        .X(x_a), .Y(y_a), .LINE_START(ls_a), .FRAME_START(fs_a), .FRAME_END(fe_a));

    vga_timing_gen #(.H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_DISPLAY(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(0), .V_POL(0), .CW(4), .OUT_DLY(3)) u_b (
        .CLK(CLK), .RESET(RESET), .CE(ce_s), .HSYNC(hs_b), .VSYNC(vs_b), .VIDEO_ON(vid_b),
        .X(x_b), .Y(y_b), .LINE_START(ls_b), .FRAME_START(fs_b), .FRAME_END(fe_b));

    vga_timing_gen #(.H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_DISPLAY(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1), .CW(4), .OUT_DLY(1)) u_p (
        .CLK(CLK), .RESET(RESET), .CE(ce_s), .HSYNC(hs_p), .VSYNC(vs_p), .VIDEO_ON(vid_p),
        .X(x_p), .Y(y_p), .LINE_START(ls_p), .FRAME_START(fs_p), .FRAME_END(fe_p));

    vga_timing_gen u_g (
        .CLK(CLK), .RESET(RESET), .CE(ce_b), .HSYNC(hs_g), .VSYNC(vs_g), .VIDEO_ON(vid_g),
        .X(x_g), .Y(y_g), .LINE_START(ls_g), .FRAME_START(fs_g), .FRAME_END(fe_g));

    exp_t act_a, act_b, act_p, act_g;
    assign act_a = {hs_a, vs_a, vid_a, ls_a, fs_a, fe_a, 12'd0, x_a, 12'd0, y_a};
    assign act_b = {hs_b, vs_b, vid_b, ls_b, fs_b, fe_b, 12'd0, x_b, 12'd0, y_b};
    assign act_p = {hs_p, vs_p, vid_p, ls_p, fs_p, fe_p, 12'd0, x_p, 12'd0, y_p};
    assign act_g = {hs_g, vs_g, vid_g, ls_g, fs_g, fe_g, 5'd0, x_g, 5'd0, y_g};

    function automatic exp_t mk(bit hs, bit vs, bit vid, bit ls, bit fs, bit fe, int x, int y);
        exp_t e;
        e = {hs, vs, vid, ls, fs, fe, 16'(x), 16'(y)};
        return e;
    endfunction

    // Outputs after n CE ticks: reset values until latency is covered, then the
    // position (n - lat) laid out as rows of ht pixels and frames of vt rows.
    function automatic exp_t model(int n, int lat, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb, bit hp, bit vp);
        int ht, vt, p, h, v;
        if (n < lat) return mk(~hp, ~vp, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        p  = n - lat;
        h  = p % ht;
        v  = (p / ht) % vt;
        return mk((h >= hd + hf && h < hd + hf + hsw) ? hp : ~hp,
                  (v >= vd + vf && v < vd + vf + vsw) ? vp : ~vp,
                  (h < hd) && (v < vd), h == 0, (h == 0) && (v == 0),
                  (h == hd - 1) && (v == vd - 1), h, v);
    endfunction

    task automatic chk(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b vid=%b ls=%b fs=%b fe=%b x=%0d y=%0d, want hs=%b vs=%b vid=%b ls=%b fs=%b fe=%b x=%0d y=%0d",
                nm, $time, act.hs, act.vs, act.vid, act.ls, act.fs, act.fe, act.x, act.y,
                exp.hs, exp.vs, exp.vid, exp.ls, exp.fs, exp.fe, exp.x, exp.y);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("model_a", act_a, model(n_s, 1, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0));
        chk("model_b", act_b, model(n_s, 4, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0));
        chk("model_p", act_p, model(n_s, 2, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1));
        chk("model_g", act_g, model(n_b, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    endtask

    task automatic step(input logic rst, input logic ces, input logic ceb);
        RESET = rst;
        ce_s  = ces;
        ce_b  = ceb;
        @(posedge CLK);
        if (rst) begin
            n_s = 0;
            n_b = 0;
        end else begin
            if (ces) n_s++;
            if (ceb) n_b++;
        end
        #1;
        check_all();
    endtask

    vec_t vecs [16];
    int   vi = 0;
    int   hs_low_clk = 0;
    int   ls_high_clk = 0;

    initial begin
        // Hand-derived small-geometry points (u_a, CE every CLK, k = CE ticks since reset).
        vecs[0]  = '{k: 0,   e: mk(1, 1, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{k: 1,   e: mk(1, 1, 1, 1, 1, 0, 0, 0)};
        vecs[2]  = '{k: 8,   e: mk(1, 1, 1, 0, 0, 0, 7, 0)};
        vecs[3]  = '{k: 9,   e: mk(1, 1, 0, 0, 0, 0, 8, 0)};
        vecs[4]  = '{k: 11,  e: mk(0, 1, 0, 0, 0, 0, 10, 0)};
        vecs[5]  = '{k: 13,  e: mk(0, 1, 0, 0, 0, 0, 12, 0)};
        vecs[6]  = '{k: 14,  e: mk(1, 1, 0, 0, 0, 0, 13, 0)};
        vecs[7]  = '{k: 15,  e: mk(1, 1, 1, 1, 0, 0, 0, 1)};
        vecs[8]  = '{k: 50,  e: mk(1, 1, 1, 0, 0, 1, 7, 3)};
        vecs[9]  = '{k: 51,  e: mk(1, 1, 0, 0, 0, 0, 8, 3)};
        vecs[10] = '{k: 71,  e: mk(1, 0, 0, 1, 0, 0, 0, 5)};
        vecs[11] = '{k: 85,  e: mk(1, 0, 0, 1, 0, 0, 0, 6)};
        vecs[12] = '{k: 99,  e: mk(1, 1, 0, 1, 0, 0, 0, 7)};
        vecs[13] = '{k: 111, e: mk(0, 1, 0, 0, 0, 0, 12, 7)};
        vecs[14] = '{k: 112, e: mk(1, 1, 0, 0, 0, 0, 13, 7)};
        vecs[15] = '{k: 113, e: mk(1, 1, 1, 1, 1, 0, 0, 0)};

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

        // Small configs at CE every CLK, default geometry at CE every 2nd CLK.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            while (vi < 16 && vecs[vi].k == n_s) begin
                chk($sformatf("vec_k%0d", vecs[vi].k), act_a, vecs[vi].e);
                vi++;
            end
            step(1'b0, 1'b1, (cyc % 2) == 0);
            if (hs_g == 1'b0) hs_low_clk++;
            if (ls_g == 1'b1) ls_high_clk++;
        end
        chk_int("table_reached", vi, 16);
        chk_int("hsync_low_clk", hs_low_clk, 192);
        chk_int("line_start_clk", ls_high_clk, 4);

        // Random CE streams, frozen outputs on idle cycles are covered by the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Mid-frame reset with CE held high, then restart latency.
        step(1'b1, 1'b1, 1'b1);
        chk_int("rst_x_a", int'(x_a), 0);
        chk_int("rst_y_g", int'(y_g), 0);
        chk_int("rst_vid_a", int'(vid_a), 0);
        chk_int("rst_hs_p", int'(hs_p), 0);
        chk_int("rst_hs_g", int'(hs_g), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk_int("fs_b_early", int'(fs_b), 0);
        step(1'b0, 1'b1, 1'b1);
        chk_int("fs_b_lat4", int'(fs_b), 1);
        chk_int("ls_b_x0", int'(ls_b), 1);
        chk_int("x_b_x0", int'(x_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
